fpu_sched: RTL and testbench
============================

Name: fpu_sched

Overview:
- Two-port issue scheduler in front of the single shared multi-cycle `fpu` unit.
- Arbitrates FP requests from two requesters (port 0 = main issue stage, port 1 = secondary/IO issue path) with round-robin fairness.
- Drives the fpu start protocol and holds the operands stable for the whole operation.
- Returns a tagged result to the requester that issued it. Guards with an illegal-op reject and a watchdog.

Parameters:
- TAG_W, 5, width of the requester destination tag, carried through unchanged.
- TIMEOUT_CYC, 255, maximum cycles in WAIT before the op is aborted with an error.

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous reset, active-high
- req_valid  in  2  per-port request valid
- req_ready  out  2  per-port accept; at most one bit high
- req_op  in  2x4  per-port ALUOp
- req_a  in  2x32  per-port operand 1
- req_b  in  2x32  per-port operand 2
- req_tag  in  2xTAG_W  per-port destination tag
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result accepted
- rsp_port  out  1  originating port
- rsp_tag  out  TAG_W  originating tag
- rsp_data  out  32  result; compares give a 0/1 result in bits [7:0], upper bits zero
- rsp_is_fp  out  1  result targets the FP register file (fpu AorF_)
- rsp_err  out  1  response carries an illegal-op or timeout error
- err_timeout  out  1  sticky timeout flag
- fpu_distinct  out  1  start pulse to fpu
- fpu_AorF  out  1  FP-op select to fpu
- fpu_ALUOp  out  4  op to fpu
- fpu_op1  out  32  operand 1 to fpu
- fpu_op2  out  32  operand 2 to fpu
- fpu_AorF_  in  1  destination class from fpu
- fpu_result  in  32  fpu result
- fpu_valid  in  1  fpu one-cycle done pulse

Behaviour:
- Clock and reset: all state changes on posedge CLK. Synchronous, active-high reset.
- Reset values: state=IDLE; rr_last=1, so port 0 wins first; all outputs 0; err_timeout=0.
- Legal ops: 0011 fadd, 0100 fsub, 1110 fmul, 1101 fdiv, 1100 fceq, 1011 fcle, 1010 fclt.

State machine:
- IDLE
  - req_ready is combinational: only in IDLE, and only to the grant winner.
  - Grant: round-robin on req_valid. If both ports are valid, the port != rr_last wins.
  - On handshake: latch op, a, b, tag and port into the hold registers; update rr_last.
  - Legal op -> ISSUE. Illegal op -> RESP with rsp_err=1 and rsp_data=0, fpu untouched.
- ISSUE (exactly 1 cycle)
  - fpu_distinct=1 and fpu_AorF=1.
  - fpu_ALUOp, fpu_op1 and fpu_op2 driven from the hold registers.
  - Clear the watchdog counter. Go to WAIT.
- WAIT
  - fpu_distinct=0. fpu_ALUOp, fpu_op1 and fpu_op2 stay stable, because the fpu samples op1 and op2 in later cycles.
  - Watchdog counts each cycle.
  - On fpu_valid: capture fpu_result and fpu_AorF_ -> RESP with rsp_err=0.
  - If the counter reaches TIMEOUT_CYC: set err_timeout; go to RESP with rsp_err=1, rsp_data=0.
- RESP
  - rsp_valid=1; payload held stable until rsp_ready.
  - On rsp_valid & rsp_ready: after a completed op -> GAP; after a reject or timeout -> IDLE.
- GAP (1 cycle)
  - The fpu needs one cycle after its done pulse to return to its idle state. Then -> IDLE.

Timing and latency:
- Next fpu_distinct comes no earlier than 3 cycles after an fpu_valid.
- Accept at cycle t: fpu_distinct at t+1. rsp_valid at the cycle after fpu_valid, with rsp_ready already high.
- Back-to-back accepts are at least 4 cycles apart when rsp_ready is held high.
- A stray fpu_valid outside WAIT is ignored.

Boundary conditions:
- A request arriving while busy sees req_ready=0 and must hold req_valid.
- Reset mid-operation returns to IDLE immediately. The fpu shares the same reset, so no drain is needed.
- After a timeout the fpu may be wedged. err_timeout stays set until reset; later ops are still attempted.

Decomposition:
- fpu_pkg holds:
  - localparams for the 7 ALUOp codes.
  - the sched_state_t enum: IDLE, ISSUE, WAIT, RESP, GAP.
  - an is_legal_fpu_op function.
- One sub-module: rr_arb2 (2-way round-robin grant with a last-grant register).

Test Plan:
- Port 0 fadd, a=0x3F800000, b=0x40000000, fpu model with 4-cycle latency -> rsp_data=0x40400000, rsp_port=0, rsp_is_fp=1, rsp_err=0, tag echoed; fpu_op1 and fpu_op2 stable from the ISSUE cycle to fpu_valid.
- Both ports valid every cycle, 6 ops -> grants alternate 0,1,0,1,0,1; req_ready is never high on both ports.
- Port 1 fclt, a=0xBF800000, b=0x0 -> rsp_data=0x00000001, rsp_is_fp=0.
- Illegal op 0000 -> no fpu_distinct, rsp_err=1, rsp_data=0 on the cycle after accept.
- fpu model never asserts valid -> rsp_err=1 and err_timeout=1 after TIMEOUT_CYC WAIT cycles; the next request is accepted.
- rsp_ready held low 10 cycles, with reset pulsed mid-WAIT in a second run -> payload held stable throughout the stall; after reset all outputs are 0 and port 0 wins first.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu issue scheduler.
// Contents:
//   - the ALUOp codes the shared fpu understands
//   - sched_state_t, the scheduler's state encoding
//   - is_legal_fpu_op / is_cmp_op, which classify an op code
package fpu_pkg;

    localparam logic [3:0] OP_FADD = 4'b0011;
    localparam logic [3:0] OP_FSUB = 4'b0100;
    localparam logic [3:0] OP_FMUL = 4'b1110;
    localparam logic [3:0] OP_FDIV = 4'b1101;
    localparam logic [3:0] OP_FCEQ = 4'b1100;
    localparam logic [3:0] OP_FCLE = 4'b1011;
    localparam logic [3:0] OP_FCLT = 4'b1010;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        GAP
    } sched_state_t;

    function automatic logic is_legal_fpu_op(input logic [3:0] op);
        case (op)
            OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV,
            OP_FCEQ, OP_FCLE, OP_FCLT: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // Compares produce a 0/1 result in the low byte only.
    function automatic logic is_cmp_op(input logic [3:0] op);
        case (op)
            OP_FCEQ, OP_FCLE, OP_FCLT: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a last-grant register.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   req        : per-requester request
//   en         : a grant is being taken this cycle; advance rr_last
//   grant      : one-hot grant (zero when nothing requests)
//   idx        : index of the winning requester
// When both request, the one that did not win last time wins. rr_last
// resets to 1 so requester 0 wins the first contested round.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant,
    output logic       idx
);

    logic rr_last;

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) idx = ~rr_last;
        else              idx = req[1];
        if (|req) grant[idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)   rr_last <= 1'b1;
        else if (en) rr_last <= idx;
    end

endmodule

// File: rtl/fpu_sched.sv
// Two-port issue scheduler in front of one shared multi-cycle fpu.
// Ports:
//   CLK, reset           : clock, synchronous active-high reset
//   req_*                : two request ports (valid/ready, op, operands, tag)
//   rsp_*                : tagged response back to the issuing port
//   err_timeout          : sticky watchdog flag, cleared only by reset
//   fpu_distinct/AorF/ALUOp/op1/op2 : start protocol and operands to the fpu
//   fpu_AorF_/result/valid          : completion from the fpu
// Illegal ops are answered with an error without touching the fpu. The
// operands stay on the fpu bus for the whole op because the fpu samples
// them after the start pulse.
module fpu_sched
    import fpu_pkg::*;
#(
    parameter int TAG_W       = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][3:0]       req_op,
    input  logic [1:0][31:0]      req_a,
    input  logic [1:0][31:0]      req_b,
    input  logic [1:0][TAG_W-1:0] req_tag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_port,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic [31:0]           rsp_data,
    output logic                  rsp_is_fp,
    output logic                  rsp_err,
    output logic                  err_timeout,
    output logic                  fpu_distinct,
    output logic                  fpu_AorF,
    output logic [3:0]            fpu_ALUOp,
    output logic [31:0]           fpu_op1,
    output logic [31:0]           fpu_op2,
    input  logic                  fpu_AorF_,
    input  logic [31:0]           fpu_result,
    input  logic                  fpu_valid
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    sched_state_t     state, state_nxt;
    logic [1:0]       grant;
    logic             win;
    logic             accept;
    logic             op_live;
    logic             wd_expired;
    logic [WD_W-1:0]  wd;

    logic [3:0]       h_op;
    logic [31:0]      h_a, h_b;
    logic [TAG_W-1:0] h_tag;
    logic             h_port;

    // Only IDLE exposes the grant, so at most one ready bit is ever high.
    assign accept = (state == IDLE) && (|req_valid);

    rr_arb2 u_arb (
        .clk   (CLK),
        .reset (reset),
        .req   (req_valid),
        .en    (accept),
        .grant (grant),
        .idx   (win)
    );

    // Counter holds the number of WAIT cycles already spent.
    assign wd_expired = (wd == WD_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_nxt    = state;
        req_ready    = 2'b00;
        rsp_valid    = 1'b0;
        fpu_distinct = 1'b0;
        op_live      = (state == ISSUE) || (state == WAIT);
        case (state)
            IDLE: begin
                req_ready = grant;
                if (accept)
                    state_nxt = is_legal_fpu_op(req_op[win]) ? ISSUE : RESP;
            end
            ISSUE: begin
                fpu_distinct = 1'b1;
                state_nxt    = WAIT;
            end
            WAIT: begin
                if (fpu_valid || wd_expired) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = rsp_err ? IDLE : GAP;
            end
            // fpu returns to idle one cycle after its done pulse.
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        fpu_AorF  = op_live;
        fpu_ALUOp = op_live ? h_op : 4'h0;
        fpu_op1   = op_live ? h_a  : 32'h0;
        fpu_op2   = op_live ? h_b  : 32'h0;
        rsp_port  = (state == RESP) ? h_port : 1'b0;
        rsp_tag   = (state == RESP) ? h_tag  : '0;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= IDLE;
            h_op        <= 4'h0;
            h_a         <= 32'h0;
            h_b         <= 32'h0;
            h_tag       <= '0;
            h_port      <= 1'b0;
            wd          <= '0;
            rsp_data    <= 32'h0;
            rsp_is_fp   <= 1'b0;
            rsp_err     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    h_op   <= req_op[win];
                    h_a    <= req_a[win];
                    h_b    <= req_b[win];
                    h_tag  <= req_tag[win];
                    h_port <= win;
                    if (!is_legal_fpu_op(req_op[win])) begin
                        rsp_data  <= 32'h0;
                        rsp_is_fp <= 1'b0;
                        rsp_err   <= 1'b1;
                    end
                end
                ISSUE: wd <= '0;
                WAIT: begin
                    wd <= wd + WD_W'(1);
                    // A done pulse in the last WAIT cycle still wins.
                    if (fpu_valid) begin
                        rsp_data  <= is_cmp_op(h_op) ? {24'h0, fpu_result[7:0]} : fpu_result;
                        rsp_is_fp <= fpu_AorF_;
                        rsp_err   <= 1'b0;
                    end else if (wd_expired) begin
                        rsp_data    <= 32'h0;
                        rsp_is_fp   <= 1'b0;
                        rsp_err     <= 1'b1;
                        err_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_sched.sv
// Self-checking bench for fpu_sched: randomized requests on both ports, a
// behavioural fpu with programmable latency, and a reference model that
// predicts ready, start pulses, responses and the timeout flag per cycle.
module tb_fpu_sched;

    localparam int TAG_W       = 5;
    localparam int TIMEOUT_CYC = 255;

    logic                  CLK, reset;
    logic [1:0]            req_valid, req_ready;
    logic [1:0][3:0]       req_op;
    logic [1:0][31:0]      req_a, req_b;
    logic [1:0][TAG_W-1:0] req_tag;
    logic                  rsp_valid, rsp_ready, rsp_port, rsp_is_fp, rsp_err, err_timeout;
    logic [TAG_W-1:0]      rsp_tag;
    logic [31:0]           rsp_data;
    logic                  fpu_distinct, fpu_AorF, fpu_AorF_, fpu_valid;
    logic [3:0]            fpu_ALUOp;
    logic [31:0]           fpu_op1, fpu_op2, fpu_result;

    fpu_sched #(.TAG_W(TAG_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .CLK(CLK), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_port(rsp_port),
        .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_is_fp(rsp_is_fp),
        .rsp_err(rsp_err), .err_timeout(err_timeout),
        .fpu_distinct(fpu_distinct), .fpu_AorF(fpu_AorF), .fpu_ALUOp(fpu_ALUOp),
        .fpu_op1(fpu_op1), .fpu_op2(fpu_op2), .fpu_AorF_(fpu_AorF_),
        .fpu_result(fpu_result), .fpu_valid(fpu_valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]       op;
        logic [31:0]      a, b;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef struct {
        logic             port;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             is_fp;
        logic             err;
    } rsp_t;

    int   n_chk = 0, n_pass = 0;
    int   cyc = 0;

    // stimulus knobs
    int   bubble_pct = 0, ready_pct = 100, stray_pct = 0, stall_n = 0, lat_mode = 4;

    // reference model state
    req_t q0[$], q1[$];
    rsp_t eq[$];
    logic pres[2];
    logic busy, rsp_pend, exp_tmo, tmo_due, prev_ok;
    int   idle_from, issue_cyc, wait_end, fv_cyc, rsp_due, rr_last;
    int   last_accept, last_fv, stall_left, n_accept;
    req_t cur;
    logic [31:0] fv_res;
    logic fv_aorf;
    int   grant_log[$];
    logic [31:0] last_d;
    logic last_fp, last_err;

    logic [31:0] ftab [7] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'hBF800000,
                              32'h3F000000, 32'h40400000, 32'h3FC00000};
    logic [3:0]  legal_tab [7] = '{4'b0011, 4'b0100, 4'b1110, 4'b1101, 4'b1100, 4'b1011, 4'b1010};
    logic [3:0]  bad_tab [4] = '{4'b0000, 4'b0001, 4'b0111, 4'b1111};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    endtask

    // single <-> double conversion for normal numbers and zero
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'h0) d = {f[31], 63'h0};
        else d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'h0) return {d[63], 31'h0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        logic ok = 1'b0;
        for (int i = 0; i < 7; i++) if (legal_tab[i] == op) ok = 1'b1;
        return ok;
    endfunction

    function automatic int qsz(input int p);
        return (p == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_t r;
        r.op = op; r.a = a; r.b = b; r.tag = TAG_W'($urandom);
        if (p == 0) q0.push_back(r); else q1.push_back(r);
    endtask

    task automatic push_rand(input int p);
        logic [3:0] op;
        logic [31:0] b;
        if ($urandom_range(9) == 0) op = bad_tab[$urandom_range(3)];
        else op = legal_tab[$urandom_range(6)];
        b = (op == 4'b1101) ? ftab[$urandom_range(6, 1)] : ftab[$urandom_range(6)];
        push(p, op, ftab[$urandom_range(6)], b);
    endtask

    task automatic model_clear();
        q0.delete(); q1.delete(); eq.delete(); grant_log.delete();
        pres[0] = 1'b0; pres[1] = 1'b0;
        busy = 1'b0; rsp_pend = 1'b0; exp_tmo = 1'b0; tmo_due = 1'b0; prev_ok = 1'b0;
        idle_from = 0; issue_cyc = -1; wait_end = -1; fv_cyc = -1; rsp_due = -1;
        rr_last = 1; last_accept = -1000; last_fv = -1000; stall_left = 0;
    endtask

    task automatic accept(input int p);
        req_t r;
        rsp_t e;
        real  x, y, z;
        int   lat;
        logic bit0;
        r = (p == 0) ? q0.pop_front() : q1.pop_front();
        pres[p] = 1'b0;
        grant_log.push_back(p);
        n_accept++;
        if (prev_ok) chk("accept_spacing", 64'(cyc - last_accept >= 4), 1);
        last_accept = cyc;
        rr_last = p;
        busy = 1'b1;
        e.port = p[0]; e.tag = r.tag;
        tmo_due = 1'b0;
        if (!is_legal(r.op)) begin
            e.data = 32'h0; e.is_fp = 1'b0; e.err = 1'b1;
            rsp_due = cyc + 1;
        end else begin
            cur = r;
            issue_cyc = cyc + 1;
            x = f2r(r.a); y = f2r(r.b);
            case (r.op)
                4'b0011: z = x + y;
                4'b0100: z = x - y;
                4'b1110: z = x * y;
                default: z = x / y;
            endcase
            case (r.op)
                4'b1100: bit0 = (x == y);
                4'b1011: bit0 = (x <= y);
                default: bit0 = (x < y);
            endcase
            if (r.op[3:2] == 2'b10 || r.op == 4'b1100 || r.op == 4'b1011) begin
                fv_res = 32'hA5A5A500 | {31'h0, bit0}; fv_aorf = 1'b0;
                e.data = {31'h0, bit0}; e.is_fp = 1'b0;
            end else begin
                fv_res = r2f(z); fv_aorf = 1'b1;
                e.data = fv_res; e.is_fp = 1'b1;
            end
            e.err = 1'b0;
            lat = (lat_mode < 0) ? int'($urandom_range(8, 1)) : lat_mode;
            if (lat == 0) begin
                fv_cyc = -1;
                rsp_due = cyc + 2 + TIMEOUT_CYC;
                e.data = 32'h0; e.is_fp = 1'b0; e.err = 1'b1;
                tmo_due = 1'b1;
            end else begin
                fv_cyc = issue_cyc + lat;
                rsp_due = fv_cyc + 1;
            end
            wait_end = rsp_due - 1;
        end
        eq.push_back(e);
    endtask

    task automatic step();
        logic [1:0] exp_rdy, hs;
        logic       exp_idle;
        req_t       r;
        rsp_t       e;
        @(negedge CLK);
        cyc++;
        if (cyc == rsp_due) begin
            rsp_pend = 1'b1;
            stall_left = (stall_n < 0) ? int'($urandom_range(3)) : stall_n;
            if (tmo_due) exp_tmo = 1'b1;
        end
        for (int p = 0; p < 2; p++) begin
            if (!pres[p] && qsz(p) > 0 && $urandom_range(99) >= bubble_pct) pres[p] = 1'b1;
            if (pres[p]) begin
                r = (p == 0) ? q0[0] : q1[0];
                req_valid[p] = 1'b1; req_op[p] = r.op; req_a[p] = r.a; req_b[p] = r.b; req_tag[p] = r.tag;
            end else begin
                req_valid[p] = 1'b0; req_op[p] = 4'($urandom); req_a[p] = $urandom;
                req_b[p] = $urandom; req_tag[p] = TAG_W'($urandom);
            end
        end
        fpu_valid = 1'b0; fpu_result = $urandom; fpu_AorF_ = 1'($urandom);
        if (cyc == fv_cyc) begin
            fpu_valid = 1'b1; fpu_result = fv_res; fpu_AorF_ = fv_aorf; last_fv = cyc;
        end else if (!busy && $urandom_range(99) < stray_pct) fpu_valid = 1'b1;
        if (rsp_pend && stall_left > 0) begin
            rsp_ready = 1'b0; stall_left--;
        end else rsp_ready = ($urandom_range(99) < ready_pct);
        #1;
        exp_idle = !busy && cyc >= idle_from;
        exp_rdy = 2'b00;
        if (exp_idle) begin
            if (req_valid == 2'b11) exp_rdy = (rr_last == 0) ? 2'b10 : 2'b01;
            else exp_rdy = req_valid;
        end
        chk("req_ready", req_ready, exp_rdy);
        chk("fpu_distinct", fpu_distinct, cyc == issue_cyc);
        if (cyc == issue_cyc) begin
            chk("fpu_AorF", fpu_AorF, 1);
            chk("valid_to_start", 64'(cyc - last_fv >= 3), 1);
        end
        if (issue_cyc >= 0 && cyc >= issue_cyc && cyc <= wait_end)
            chk("fpu_operands", {fpu_ALUOp, fpu_op1, fpu_op2}, {cur.op, cur.a, cur.b});
        chk("rsp_valid", rsp_valid, rsp_pend);
        if (rsp_pend && eq.size() > 0) begin
            e = eq[0];
            chk("rsp_payload", {rsp_port, rsp_tag, rsp_data, rsp_is_fp, rsp_err},
                {e.port, e.tag, e.data, e.is_fp, e.err});
        end
        chk("err_timeout", err_timeout, exp_tmo);
        hs = req_valid & exp_rdy;
        for (int p = 0; p < 2; p++) if (hs[p]) accept(p);
        if (rsp_pend && rsp_ready && eq.size() > 0) begin
            e = eq.pop_front();
            last_d = rsp_data; last_fp = rsp_is_fp; last_err = rsp_err;
            rsp_pend = 1'b0; busy = 1'b0; tmo_due = 1'b0;
            idle_from = cyc + (e.err ? 1 : 2);
            prev_ok = !e.err;
            issue_cyc = -1; wait_end = -1;
        end
    endtask

    task automatic run_done(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || busy) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk("drain_bound", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        cyc++;
        reset = 1'b1; req_valid = 2'b00; fpu_valid = 1'b0; rsp_ready = 1'b0;
        repeat (2) begin @(negedge CLK); cyc++; end
        #1;
        chk("rst_ctl", {req_ready, rsp_valid, rsp_port, rsp_tag, rsp_is_fp, rsp_err,
                        err_timeout, fpu_distinct, fpu_AorF, fpu_ALUOp}, 0);
        chk("rst_data", {rsp_data, fpu_op1}, 0);
        chk("rst_op2", fpu_op2, 0);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        reset = 1'b1; req_valid = 2'b00; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
        rsp_ready = 1'b0; fpu_AorF_ = 1'b0; fpu_result = 32'h0; fpu_valid = 1'b0;
        n_accept = 0;
        model_clear();
        do_reset();

        // fadd 1.0 + 2.0 on port 0, 4-cycle fpu
        lat_mode = 4;
        push(0, 4'b0011, 32'h3F800000, 32'h40000000);
        run_done(100);
        chk("fadd_data", last_d, 32'h40400000);
        chk("fadd_fp", last_fp, 1);

        // both ports always valid -> strict alternation from port 0
        do_reset();
        lat_mode = 2;
        for (int i = 0; i < 3; i++) begin push_rand(0); push_rand(1); end
        for (int i = 0; i < 3; i++) begin q0[i].op = 4'b1110; q1[i].op = 4'b0100; end
        run_done(300);
        chk("alt_count", grant_log.size(), 6);
        for (int i = 0; i < grant_log.size() && i < 6; i++) chk("alt_grant", grant_log[i], i % 2);

        // port 1 fclt -1.0 < 0.0
        push(1, 4'b1010, 32'hBF800000, 32'h00000000);
        run_done(100);
        chk("fclt_data", last_d, 32'h1);
        chk("fclt_fp", last_fp, 0);

        // illegal op
        push(0, 4'b0000, 32'h12345678, 32'h9ABCDEF0);
        run_done(100);
        chk("illegal_err", last_err, 1);
        chk("illegal_data", last_d, 0);

        // watchdog: fpu never completes, then a normal op is still served
        lat_mode = 0;
        push(1, 4'b1101, 32'h40400000, 32'h40000000);
        run_done(TIMEOUT_CYC + 50);
        chk("tmo_err", last_err, 1);
        lat_mode = 3;
        n_accept = 0;
        push(0, 4'b0011, 32'h3F000000, 32'h3F000000);
        run_done(100);
        chk("post_tmo_accept", n_accept, 1);
        chk("post_tmo_sticky", err_timeout, 1);

        // response stalled for 10 cycles
        stall_n = 10;
        push(0, 4'b1110, 32'h40000000, 32'h40400000);
        run_done(100);
        chk("stall_data", last_d, 32'h40C00000);
        stall_n = 0;

        // reset in the middle of WAIT
        lat_mode = 20;
        push(1, 4'b0011, 32'h3F800000, 32'h3F800000);
        for (int n = 0; n < 50 && !(issue_cyc >= 0 && cyc == issue_cyc + 3); n++) step();
        chk("mid_wait_reached", 64'(issue_cyc >= 0 && cyc == issue_cyc + 3), 1);
        do_reset();
        lat_mode = 2;
        push(0, 4'b0011, 32'h3F800000, 32'h3F800000);
        push(1, 4'b0100, 32'h3F800000, 32'h3F800000);
        run_done(100);
        chk("rst_first_port", grant_log.size() > 0 ? grant_log[0] : 99, 0);

        // randomized traffic
        lat_mode = -1; bubble_pct = 30; ready_pct = 70; stray_pct = 10; stall_n = -1;
        for (int i = 0; i < 40; i++) push_rand(int'($urandom_range(1)));
        run_done(3000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
